// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int WB_DIR_WIDTH  = 5;
    localparam int WB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [WB_DIR_WIDTH-1:0]  dir;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_e;

    localparam logic [WB_DIR_WIDTH-1:0] REG_ZERO = '0;

    // Writes to the hardwired zero register are swallowed before buffering.
    function automatic logic is_reg_zero(input logic [WB_DIR_WIDTH-1:0] dir);
        return (dir == REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// Synchronous FIFO holding pending register writes for one producer.
import regfile_wb_pkg::*;

module wb_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t         mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents beyond the count are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Buffers ALU and MEM write-backs and drives the register file's single write port round-robin.
import regfile_wb_pkg::*;

module regfile_writeback_arbiter #(
    parameter int DIR_WIDTH  = WB_DIR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [DIR_WIDTH-1:0]  alu_dir,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [DIR_WIDTH-1:0]  mem_dir,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  write_en,
    output logic [DIR_WIDTH-1:0]  write_dir,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  idle
);

    wb_entry_t             alu_entry_s, mem_entry_s, alu_head_s, mem_head_s;
    logic                  alu_full_s, alu_empty_s, mem_full_s, mem_empty_s;
    logic                  alu_push_s, mem_push_s, alu_pop_s, mem_pop_s;
    wb_src_e               rr_ptr_r;
    logic                  write_en_r;
    logic [DIR_WIDTH-1:0]  write_dir_r;
    logic [DATA_WIDTH-1:0] write_data_r;

    assign alu_entry_s = '{dir: alu_dir, data: alu_data};
    assign mem_entry_s = '{dir: mem_dir, data: mem_data};

    // Ready looks only at registered fullness, never at a same-cycle pop.
    assign alu_ready  = !alu_full_s;
    assign mem_ready  = !mem_full_s;
    assign alu_push_s = alu_valid && !alu_full_s && !flush && !is_reg_zero(alu_dir);
    assign mem_push_s = mem_valid && !mem_full_s && !flush && !is_reg_zero(mem_dir);

    wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_alu_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .push(alu_push_s), .push_data(alu_entry_s), .pop(alu_pop_s),
        .full(alu_full_s), .empty(alu_empty_s), .head(alu_head_s)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wb_entry_t)) u_mem_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .push(mem_push_s), .push_data(mem_entry_s), .pop(mem_pop_s),
        .full(mem_full_s), .empty(mem_empty_s), .head(mem_head_s)
    );

    // Round-robin grant: a lone non-empty source always wins, ties go to rr_ptr.
    always_comb begin
        alu_pop_s = 1'b0;
        mem_pop_s = 1'b0;
        if (!alu_empty_s && (mem_empty_s || rr_ptr_r == SRC_ALU)) begin
            alu_pop_s = 1'b1;
        end else if (!mem_empty_s) begin
            mem_pop_s = 1'b1;
        end else begin
            alu_pop_s = 1'b0;
            mem_pop_s = 1'b0;
        end
    end

    // Output register and arbitration pointer; rst outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_r   <= 1'b0;
            write_dir_r  <= '0;
            write_data_r <= '0;
            rr_ptr_r     <= SRC_ALU;
        end else if (flush) begin
            write_en_r <= 1'b0;
            rr_ptr_r   <= SRC_ALU;
        end else if (alu_pop_s) begin
            write_en_r   <= 1'b1;
            write_dir_r  <= alu_head_s.dir;
            write_data_r <= alu_head_s.data;
            rr_ptr_r     <= SRC_MEM;
        end else if (mem_pop_s) begin
            write_en_r   <= 1'b1;
            write_dir_r  <= mem_head_s.dir;
            write_data_r <= mem_head_s.data;
            rr_ptr_r     <= SRC_ALU;
        end else begin
            write_en_r <= 1'b0;
        end
    end

    assign write_en   = write_en_r;
    assign write_dir  = write_dir_r;
    assign write_data = write_data_r;
    assign idle       = alu_empty_s && mem_empty_s && !write_en_r;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with a queue-level reference model.
import regfile_wb_pkg::*;

module tb_regfile_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        alu_valid, mem_valid, alu_ready, mem_ready;
    logic [4:0]  alu_dir, mem_dir, write_dir;
    logic [31:0] alu_data, mem_data, write_data;
    logic        write_en, idle;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    wb_entry_t alu_pend[$];
    wb_entry_t mem_pend[$];
    int        log_dir[$];
    int        log_cyc[$];

    // reference model state
    wb_entry_t   mq_a[$];
    wb_entry_t   mq_m[$];
    bit          m_rr;
    bit          m_en;
    logic [4:0]  m_dir;
    logic [31:0] m_data;
    bit          model_on = 1'b0;
    bit          a_rdy, b_rdy;
    wb_entry_t   m_e;

    regfile_writeback_arbiter #(.DIR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dir(alu_dir), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dir(mem_dir), .mem_data(mem_data),
        .write_en(write_en), .write_dir(write_dir), .write_data(write_data), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: one write per edge from the queue heads, then accept new transfers.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq_a.delete(); mq_m.delete();
            m_rr = 1'b0; m_en = 1'b0; m_dir = '0; m_data = '0;
            model_on = 1'b1;
        end else if (flush) begin
            mq_a.delete(); mq_m.delete();
            m_rr = 1'b0; m_en = 1'b0;
        end else begin
            a_rdy = mq_a.size() < DEPTH;
            b_rdy = mq_m.size() < DEPTH;
            if (mq_a.size() > 0 && (mq_m.size() == 0 || m_rr == 1'b0)) begin
                m_e = mq_a.pop_front(); m_en = 1'b1; m_dir = m_e.dir; m_data = m_e.data; m_rr = 1'b1;
            end else if (mq_m.size() > 0) begin
                m_e = mq_m.pop_front(); m_en = 1'b1; m_dir = m_e.dir; m_data = m_e.data; m_rr = 1'b0;
            end else begin
                m_en = 1'b0;
            end
            if (alu_valid && a_rdy && alu_dir != 5'd0) mq_a.push_back('{dir: alu_dir, data: alu_data});
            if (mem_valid && b_rdy && mem_dir != 5'd0) mq_m.push_back('{dir: mem_dir, data: mem_data});
        end
    end

    // Every-cycle comparison against the model, plus a log of observed writes.
    always @(negedge clk) begin
        if (model_on) begin
            check("write_en", write_en, m_en);
            check("write_dir", write_dir, m_dir);
            check("write_data", write_data, m_data);
            check("alu_ready", alu_ready, mq_a.size() < DEPTH);
            check("mem_ready", mem_ready, mq_m.size() < DEPTH);
            check("idle", idle, mq_a.size() == 0 && mq_m.size() == 0 && !m_en);
            if (write_en) begin
                log_dir.push_back(int'(write_dir));
                log_cyc.push_back(cyc);
            end
        end
    end

    // Offer pending entries, cross one edge, retire what was accepted.
    task automatic tick();
        bit ar, mr;
        alu_valid = alu_pend.size() > 0;
        mem_valid = mem_pend.size() > 0;
        if (alu_valid) begin alu_dir = alu_pend[0].dir; alu_data = alu_pend[0].data; end
        if (mem_valid) begin mem_dir = mem_pend[0].dir; mem_data = mem_pend[0].data; end
        ar = alu_ready;
        mr = mem_ready;
        @(posedge clk);
        if (alu_valid && ar && !rst && !flush) void'(alu_pend.pop_front());
        if (mem_valid && mr && !rst && !flush) void'(mem_pend.pop_front());
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    int exp_rr[8] = '{1, 11, 2, 12, 3, 13, 4, 14};

    initial begin
        int  nexp;
        bit  saw_full, done;
        rst = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_dir = '0; mem_dir = '0; alu_data = '0; mem_data = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_write_en", write_en, 1'b0);
        check("rst_write_dir", write_dir, 5'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_ready", {alu_ready, mem_ready}, 2'b11);
        check("rst_idle", idle, 1'b1);

        // single ALU write: dir 5 appears exactly two edges after acceptance
        alu_pend.push_back('{dir: 5'd5, data: 32'hDEADBEEF});
        tick();
        check("single_e0_en", write_en, 1'b0);
        tick();
        check("single_e1_en", write_en, 1'b1);
        check("single_e1_dir", write_dir, 5'd5);
        check("single_e1_data", write_data, 32'hDEADBEEF);
        tick();
        check("single_e2_en", write_en, 1'b0);
        check("single_idle", idle, 1'b1);

        // register-0 write is swallowed
        mem_pend.push_back('{dir: 5'd0, data: 32'h1234});
        tick();
        check("r0_mem_ready", mem_ready, 1'b1);
        check("r0_idle", idle, 1'b1);
        tick();
        check("r0_no_write", write_en, 1'b0);

        // round-robin interleave
        do_flush();
        log_dir.delete(); log_cyc.delete();
        for (int i = 1; i <= 4; i++) begin
            alu_pend.push_back('{dir: 5'(i), data: 32'(i * 256)});
            mem_pend.push_back('{dir: 5'(i + 10), data: 32'((i + 10) * 256)});
        end
        repeat (12) tick();
        check("rr_count", log_dir.size(), 8);
        for (int i = 0; i < 8 && i < log_dir.size(); i++) begin
            check("rr_dir", log_dir[i], exp_rr[i]);
            check("rr_back_to_back", log_cyc[i] - log_cyc[0], i);
        end

        // backpressure: MEM pushes DEPTH+2 while ALU floods
        do_flush();
        log_dir.delete(); log_cyc.delete();
        for (int i = 0; i < DEPTH + 2; i++) mem_pend.push_back('{dir: 5'(20 + i), data: 32'(32'hA000 + i)});
        for (int i = 1; i <= 8; i++) alu_pend.push_back('{dir: 5'(i), data: 32'(32'hB000 + i)});
        saw_full = 1'b0; done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            tick();
            if (!mem_ready) saw_full = 1'b1;
            done = alu_pend.size() == 0 && mem_pend.size() == 0 && idle;
        end
        check("bp_drain_in_time", done, 1'b1);
        check("bp_mem_ready_dropped", saw_full, 1'b1);
        check("bp_total_writes", log_dir.size(), 14);
        nexp = 20;
        for (int i = 0; i < log_dir.size(); i++) if (log_dir[i] >= 20) begin
            check("bp_mem_order", log_dir[i], nexp); nexp++;
        end
        check("bp_mem_all", nexp, 26);
        nexp = 1;
        for (int i = 0; i < log_dir.size(); i++) if (log_dir[i] < 20) begin
            check("bp_alu_order", log_dir[i], nexp); nexp++;
        end
        check("bp_alu_all", nexp, 9);

        // flush mid-stream: only the two writes already granted survive
        do_flush();
        log_dir.delete(); log_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            alu_pend.push_back('{dir: 5'(17 + i), data: 32'(17 + i)});
            mem_pend.push_back('{dir: 5'(21 + i), data: 32'(21 + i)});
        end
        repeat (3) tick();
        alu_pend.delete(); mem_pend.delete();
        do_flush();
        check("flush_en", write_en, 1'b0);
        check("flush_idle", idle, 1'b1);
        repeat (5) tick();
        check("flush_count", log_dir.size(), 2);
        if (log_dir.size() == 2) begin
            check("flush_w0", log_dir[0], 17);
            check("flush_w1", log_dir[1], 21);
        end

        // rst together with flush while partially full; pointer must return to ALU
        do_flush();
        for (int i = 1; i <= 3; i++) begin
            alu_pend.push_back('{dir: 5'(i), data: 32'(i)});
            mem_pend.push_back('{dir: 5'(i + 10), data: 32'(i + 10)});
        end
        repeat (2) tick();
        alu_pend.delete(); mem_pend.delete();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        check("rp_write_en", write_en, 1'b0);
        check("rp_write_dir", write_dir, 5'd0);
        check("rp_write_data", write_data, 32'd0);
        check("rp_ready", {alu_ready, mem_ready}, 2'b11);
        check("rp_idle", idle, 1'b1);
        log_dir.delete(); log_cyc.delete();
        alu_pend.push_back('{dir: 5'd4, data: 32'h44});
        mem_pend.push_back('{dir: 5'd14, data: 32'h144});
        repeat (5) tick();
        check("rp_count", log_dir.size(), 2);
        if (log_dir.size() == 2) begin
            check("rp_first_alu", log_dir[0], 4);
            check("rp_then_mem", log_dir[1], 14);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Write-side front end for the physical register file. Collects register-write results from two producers, the ALU and the load/store unit (MEM), and buffers each in its own FIFO. Arbitrates round-robin between them and drives the register file's single write port (write_en / write_dir / write_data), issuing one write per cycle. Writes targeting register 0 are accepted and discarded here, so the register file never sees them.

## Interface

Parameters:
- DIR_WIDTH, 5: register address width; must match the register file.
- DATA_WIDTH, 32: register data width.
- FIFO_DEPTH, 4: entries per source FIFO; power of two, at least 2.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- flush, input, 1: synchronous clear of both FIFOs and the output register.
- alu_valid, input, 1: ALU result valid.
- alu_ready, output, 1: ALU FIFO can accept.
- alu_dir, input, DIR_WIDTH: ALU destination register.
- alu_data, input, DATA_WIDTH: ALU result.
- mem_valid, input, 1: MEM result valid.
- mem_ready, output, 1: MEM FIFO can accept.
- mem_dir, input, DIR_WIDTH: MEM destination register.
- mem_data, input, DATA_WIDTH: MEM result.
- write_en, output, 1: register-file write enable, registered.
- write_dir, output, DIR_WIDTH: register-file write address, registered.
- write_data, output, DATA_WIDTH: register-file write data, registered.
- idle, output, 1: both FIFOs empty and write_en low.

## Operation

- Handshake:
  - A transfer occurs on a rising edge where valid and ready are both high.
  - Producers hold dir/data stable while valid is high and ready is low.
- Ready generation:
  - alu_ready = !alu_full, and likewise for MEM.
  - Ready ignores a same-cycle pop, so a full FIFO never accepts a push even while draining.
- Register-0 filtering: a transfer with dir == 0 completes but is not pushed. It does not consume an entry, and no write ever results.
- Arbitration state is a 1-bit rr_ptr (SRC_ALU or SRC_MEM):
  - Only one FIFO non-empty: pop that FIFO.
  - Both non-empty: pop the FIFO named by rr_ptr.
  - After any grant, rr_ptr becomes the other source.
  - Neither non-empty: no pop, rr_ptr unchanged.
- Output register:
  - On a pop, write_en <= 1 and write_dir/write_data <= the head entry.
  - Otherwise write_en <= 0; write_dir/write_data hold their previous values.
- Ordering:
  - Within one source, writes are strictly FIFO.
  - Across sources, order is arbitration order only. Producers must not have outstanding writes to the same register in both FIFOs.
- flush:
  - Empties both FIFOs (pointers and counts to 0) and forces write_en <= 0.
  - rr_ptr <= SRC_ALU.
  - Transfers presented in the flush cycle are dropped, even though ready may be high.
- rst has priority over flush.

## Timing

- Reset values: write_en 0, write_dir 0, write_data 0, rr_ptr SRC_ALU, both FIFOs empty.
- Consequently alu_ready = mem_ready = 1 and idle = 1 out of reset.
- Latency: a transfer accepted at edge E0 reaches the FIFO head after E0, is popped at E1, and write_en is high in the cycle after E1. Minimum latency is 2 edges, with no zero-latency bypass.
- Throughput: one write per cycle total. With both sources saturated, each source gets exactly every other cycle.
- FIFO boundaries:
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
  - A pop on an empty FIFO never occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is $clog2(FIFO_DEPTH+1) bits.
- rst or flush asserted mid-stream: in-flight entries are lost. The next write_en occurs no earlier than 2 edges after the first post-clear acceptance.
- Outputs alu_ready, mem_ready and idle are combinational from registered state only. They never depend on the valid inputs.

## Structure

- Package regfile_wb_pkg:
  - typedef wb_entry_t, a packed struct {dir, data} built from DIR_WIDTH and DATA_WIDTH.
  - typedef enum logic wb_src_e {SRC_ALU, SRC_MEM}.
  - REG_ZERO = '0.
- Sub-module wb_fifo:
  - Synchronous FIFO parameterized by FIFO_DEPTH and entry type.
  - Ports: push, pop, flush, full, empty, head.
  - Instantiated twice, once per source.
- Top level holds the filtering, the round-robin pointer, and the output register.

## Test plan

- Reset then single write: ALU sends dir 5, data 0xDEADBEEF for one cycle. Required: write_en high exactly one cycle, 2 edges later, with write_dir 5 and write_data 0xDEADBEEF; idle returns to 1 afterward.
- Register-0 drop: MEM sends dir 0, data 0x1234. Required: mem_ready stays 1, no write_en pulse, FIFO count stays 0.
- Round-robin: both sources push 4 entries back-to-back, ALU dirs 1–4 and MEM dirs 11–14. Required write_dir sequence: 1, 11, 2, 12, 3, 13, 4, 14 on 8 consecutive cycles.
- Full/backpressure: hold MEM valid with FIFO_DEPTH+2 entries while the ALU also floods.
  - mem_ready drops to 0 when the count reaches 4.
  - No entry is lost or duplicated.
  - Writes emerge in push order per source.
- Flush mid-stream: fill the ALU FIFO with 3 entries, then assert flush for one cycle. Required: write_en 0 in the next cycle, idle 1, and none of the flushed dirs ever written.
- Reset priority: assert rst and flush together with both FIFOs partially full. Required: all reset values, and rr_ptr = SRC_ALU, verified by the next simultaneous push granting ALU first.
